// File: rtl/jt03_slot_sched_pkg.sv
// rtl/jt03_slot_sched_pkg.sv - shared types and constants for the operator-slot scheduler
// Purpose: operator encodings, FSM state codes, the accumulator-side record layout
//          and the slot-count helper shared by the scheduler files.
// Ports:   none (package).
package jt03_slot_sched_pkg;

   localparam int NOP = 4;

   // Operator order inside a frame is S1, S3, S2, S4, so the issue order itself
   // is the encoding.
   typedef enum logic [1:0] {
      OP_S1 = 2'd0,
      OP_S3 = 2'd1,
      OP_S2 = 2'd2,
      OP_S4 = 2'd3
   } op_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_IDLE = 1'b1
   } state_e;

   // Record carried from the issue side to the accumulator side.
   typedef struct packed {
      logic       vld;
      logic [1:0] op;
      logic       zero;
      logic [2:0] alg;
   } acc_t;

   localparam int ACC_W = $bits(acc_t);

   function automatic int nslot(input int nch);
      return NOP * nch;
   endfunction

endpackage

// File: rtl/jt03_slot_sched_if.sv
// rtl/jt03_slot_sched_if.sv - control, config and slot bus of the operator-slot scheduler
// Purpose: bundles slot-rate control, ALG configuration, issue-side and
//          accumulator-side slot signals.
// Ports:   slave modport = scheduler view, master modport = driver/monitor view.
//          clk_en, halt          slot-rate enable, stop request
//          cfg_we/ch/alg, pend   ALG write port and pending flag
//          slot_vld/ch/op        issue side
//          s1..s4_enters, zero, alg, sample_stb   accumulator side
interface jt03_slot_sched_if;

   logic       clk_en;
   logic       halt;
   logic       cfg_we;
   logic [1:0] cfg_ch;
   logic [2:0] cfg_alg;
   logic       cfg_pend;
   logic       slot_vld;
   logic [1:0] slot_ch;
   logic [1:0] slot_op;
   logic       s1_enters;
   logic       s2_enters;
   logic       s3_enters;
   logic       s4_enters;
   logic       zero;
   logic [2:0] alg;
   logic       sample_stb;

   modport slave (
      input  clk_en, halt, cfg_we, cfg_ch, cfg_alg,
      output cfg_pend, slot_vld, slot_ch, slot_op,
      output s1_enters, s2_enters, s3_enters, s4_enters, zero, alg, sample_stb
   );

   modport master (
      output clk_en, halt, cfg_we, cfg_ch, cfg_alg,
      input  cfg_pend, slot_vld, slot_ch, slot_op,
      input  s1_enters, s2_enters, s3_enters, s4_enters, zero, alg, sample_stb
   );

endinterface

// File: rtl/jt03_sched_dly.sv
// rtl/jt03_sched_dly.sv - enable-gated delay line from issue side to accumulator side
// Purpose: OP_LAT-deep shift register advancing only on en, cleared by reset.
// Ports:   clk, rst_n   clock, asynchronous active-low clear
//          en           shift enable (slot-rate tick)
//          din, dout    W-bit record in / record OP_LAT ticks old out
module jt03_sched_dly #(
   parameter int OP_LAT = 4,
   parameter int W      = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] sr [OP_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OP_LAT; i++) sr[i] <= '0;
      end else if (en) begin
         sr[0] <= din;
         for (int i = 1; i < OP_LAT; i++) sr[i] <= sr[i-1];
      end
   end

   assign dout = sr[OP_LAT-1];

endmodule

// File: rtl/jt03_slot_sched.sv
// rtl/jt03_slot_sched.sv - operator-slot scheduler for the mono accumulator path
// Purpose: walks NCH channels x 4 operators per frame, issues slots to the operator
//          pipeline, re-times slot info OP_LAT ticks for the accumulator, and
//          owns per-channel ALG registers applied only at frame boundaries.
// Ports:   clk, rst_n   clock, asynchronous active-low reset
//          sif          jt03_slot_sched_if.slave (control, config, issue and acc sides)
module jt03_slot_sched
   import jt03_slot_sched_pkg::*;
#(
   parameter int NCH    = 3,
   parameter int OP_LAT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   jt03_slot_sched_if.slave   sif
);

   state_e           state;
   logic [1:0]       cnt_ch;
   logic [1:0]       cnt_op;
   logic [1:0]       nxt_ch;
   logic [1:0]       nxt_op;
   logic [2:0]       pend_alg [NCH];
   logic [2:0]       active   [NCH];
   logic [2:0]       pend_byp [NCH];
   logic [NCH-1:0]   dirty;
   logic [NCH-1:0]   we_c;
   logic [2:0]       alg_run;
   logic             boundary;
   logic             start;
   logic             apply;
   logic             primed;
   logic             zero_i;
   acc_t             issue_q;
   logic [1:0]       issue_ch;
   acc_t             acc_d;

   // A write landing in the same cycle as an apply is taken into that apply.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         we_c[c]     = sif.cfg_we && (sif.cfg_ch == 2'(c));
         pend_byp[c] = we_c[c] ? sif.cfg_alg : pend_alg[c];
      end
   end

   always_comb begin
      alg_run = '0;
      for (int c = 0; c < NCH; c++) begin
         if (cnt_ch == 2'(c)) alg_run = active[c];
      end
   end

   always_comb begin
      nxt_ch = cnt_ch + 2'd1;
      nxt_op = cnt_op;
      if (cnt_ch == 2'(NCH-1)) begin
         nxt_ch = '0;
         nxt_op = cnt_op + 2'd1;
      end
   end

   assign boundary = (state == ST_RUN) && (cnt_op == OP_S4) && (cnt_ch == 2'(NCH-1));
   assign start    = (state == ST_IDLE) && !sif.halt;
   assign apply    = sif.clk_en && (boundary || start);
   assign zero_i   = (cnt_ch == 2'd0) && (cnt_op == OP_S1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         cnt_ch   <= '0;
         cnt_op   <= '0;
         issue_q  <= '0;
         issue_ch <= '0;
         primed   <= 1'b0;
         dirty    <= '0;
         for (int c = 0; c < NCH; c++) begin
            pend_alg[c] <= '0;
            active[c]   <= '0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            pend_alg[c] <= pend_byp[c];
            if (apply) active[c] <= pend_byp[c];
         end
         dirty <= apply ? '0 : (dirty | we_c);

         if (sif.clk_en) begin
            if (acc_d.vld && acc_d.zero) primed <= 1'b1;
            case (state)
               ST_RUN: begin
                  // The boundary slot still carries the old ALG: active is
                  // sampled before the apply takes effect.
                  issue_q  <= {1'b1, cnt_op, zero_i, alg_run};
                  issue_ch <= cnt_ch;
                  cnt_ch   <= nxt_ch;
                  cnt_op   <= nxt_op;
                  if (boundary && sif.halt) begin
                     state  <= ST_IDLE;
                     primed <= 1'b0;
                  end
               end
               ST_IDLE: begin
                  if (!sif.halt) begin
                     // Counters are parked at 0, so slot 0 goes out now and
                     // sees the ALG being applied on this same tick.
                     state    <= ST_RUN;
                     issue_q  <= {1'b1, OP_S1, 1'b1, pend_byp[0]};
                     issue_ch <= '0;
                     cnt_ch   <= nxt_ch;
                     cnt_op   <= nxt_op;
                  end else begin
                     issue_q  <= '0;
                     issue_ch <= '0;
                  end
               end
               default: state <= ST_RUN;
            endcase
         end
      end
   end

   jt03_sched_dly #(
      .OP_LAT (OP_LAT),
      .W      (ACC_W)
   ) u_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (sif.clk_en),
      .din   (issue_q),
      .dout  (acc_d)
   );

   assign sif.slot_vld   = issue_q.vld;
   assign sif.slot_ch    = issue_ch;
   assign sif.slot_op    = issue_q.op;
   assign sif.s1_enters  = acc_d.vld && (acc_d.op == OP_S1);
   assign sif.s2_enters  = acc_d.vld && (acc_d.op == OP_S2);
   assign sif.s3_enters  = acc_d.vld && (acc_d.op == OP_S3);
   assign sif.s4_enters  = acc_d.vld && (acc_d.op == OP_S4);
   assign sif.zero       = acc_d.zero;
   assign sif.alg        = acc_d.alg;
   assign sif.sample_stb = acc_d.vld && acc_d.zero && primed;
   assign sif.cfg_pend   = |dirty;

endmodule

// File: tb/tb_jt03_slot_sched.sv
// tb/tb_jt03_slot_sched.sv - randomized self-checking bench for jt03_slot_sched
module tb_jt03_slot_sched;

   localparam int NCH    = 3;
   localparam int OP_LAT = 4;
   localparam int NSLOT  = 4 * NCH;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   jt03_slot_sched_if bus();

   jt03_slot_sched #(.NCH(NCH), .OP_LAT(OP_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit vld;
      int op;
      int ch;
      bit zero;
      int alg;
   } rec_t;

   // Reference: frames as slot numbers, ALG as plain arrays, latency as a queue
   // of issued records (front = what the accumulator sees now).
   rec_t q[$];
   int   m_pend  [4];
   int   m_act   [4];
   bit   m_dirty [4];
   bit   m_run;
   int   m_s;
   bit   m_seen;
   bit   m_stb;
   int   m_last_slot;

   function automatic rec_t zrec();
      rec_t r;
      r.vld = 0; r.op = 0; r.ch = 0; r.zero = 0; r.alg = 0;
      return r;
   endfunction

   function automatic void model_reset();
      q.delete();
      for (int i = 0; i <= OP_LAT; i++) q.push_back(zrec());
      for (int c = 0; c < 4; c++) begin
         m_pend[c] = 0; m_act[c] = 0; m_dirty[c] = 0;
      end
      m_run = 1; m_s = 0; m_seen = 0; m_stb = 0; m_last_slot = -1;
   endfunction

   function automatic void model_tick(bit en, bit halt, bit we, int ch, int alg);
      bit   ap;
      rec_t r;
      ap = 0;
      r  = zrec();
      if (we && ch < NCH) begin
         m_pend[ch]  = alg;
         m_dirty[ch] = 1;
      end
      if (en) begin
         if (m_run) begin
            r.vld = 1; r.op = m_s / NCH; r.ch = m_s % NCH;
            r.zero = (m_s == 0); r.alg = m_act[r.ch];
            m_last_slot = m_s;
            if (m_s == NSLOT - 1) begin
               ap = 1;
               if (halt) m_run = 0;
            end
            m_s = (m_s + 1) % NSLOT;
         end else if (!halt) begin
            ap = 1; m_run = 1; m_s = 1;
            r.vld = 1; r.op = 0; r.ch = 0; r.zero = 1; r.alg = m_pend[0];
            m_last_slot = 0;
         end else begin
            m_last_slot = -1;
         end
         if (ap) begin
            for (int c = 0; c < 4; c++) begin
               m_act[c] = m_pend[c];
               m_dirty[c] = 0;
            end
         end
         q.push_back(r);
         void'(q.pop_front());
         m_stb = q[0].vld && q[0].zero && m_seen;
         if (q[0].vld && q[0].zero) m_seen = 1;
         if (!m_run) m_seen = 0;
      end
   endfunction

   // {slot_vld, slot_ch, slot_op, s1, s2, s3, s4, zero, alg, sample_stb, cfg_pend}
   function automatic logic [14:0] exp_vec();
      rec_t a;
      rec_t i;
      a = q[0];
      i = q[q.size()-1];
      return {i.vld, 2'(i.ch), 2'(i.op),
              a.vld && a.op == 0, a.vld && a.op == 2, a.vld && a.op == 1, a.vld && a.op == 3,
              a.zero, 3'(a.alg), m_stb,
              m_dirty[0] | m_dirty[1] | m_dirty[2] | m_dirty[3]};
   endfunction

   function automatic logic [14:0] obs_vec();
      return {bus.slot_vld, bus.slot_ch, bus.slot_op,
              bus.s1_enters, bus.s2_enters, bus.s3_enters, bus.s4_enters,
              bus.zero, bus.alg, bus.sample_stb, bus.cfg_pend};
   endfunction

   task automatic tick(input bit en, input bit halt, input bit we, input int ch, input int alg);
      bus.clk_en  = en;
      bus.halt    = halt;
      bus.cfg_we  = we;
      bus.cfg_ch  = 2'(ch);
      bus.cfg_alg = 3'(alg);
      model_tick(en, halt, we, ch, alg);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.clk_en = 0; bus.halt = 0; bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_alg = 0;
      rst_n = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (obs_vec() !== 15'h0) begin
         $display("FAIL reset_outputs got=%h exp=%h", obs_vec(), 15'h0);
         bad++;
      end
      @(negedge clk);
      rst_n = 1;
      for (int k = 0; k < 3; k++) begin
         tick(0, 0, 0, 0, 0);
         total++;
         if (obs_vec() !== 15'h0) begin
            $display("FAIL reset_idle_en0 got=%h exp=%h", obs_vec(), 15'h0);
            bad++;
         end
      end
   endtask

   task automatic test_order();
      for (int k = 1; k <= 2 * NSLOT + OP_LAT + 2; k++) begin
         tick(1, 0, 0, 0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL order tick=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            bad++;
         end
         if (k == OP_LAT + 1) begin
            total++;
            if (bus.zero !== 1'b1 || bus.sample_stb !== 1'b0) begin
               $display("FAIL first_zero_latency zero=%b stb=%b exp zero=1 stb=0", bus.zero, bus.sample_stb);
               bad++;
            end
         end
      end
   endtask

   task automatic test_alg_write();
      for (int k = 0; k < 40 && m_last_slot != 3; k++) tick(1, 0, 0, 0, 0);
      total++;
      if (m_last_slot != 3) begin
         $display("FAIL alg_write_sync last=%0d exp=3", m_last_slot);
         bad++;
      end
      tick(1, 0, 1, 1, 5);
      total++;
      if (bus.cfg_pend !== 1'b1) begin
         $display("FAIL alg_write_pend got=%b exp=1", bus.cfg_pend);
         bad++;
      end
      for (int k = 0; k < 2 * NSLOT + OP_LAT; k++) begin
         tick(1, 0, 0, 0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL alg_write tick=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            bad++;
         end
      end
   endtask

   task automatic test_last_wins();
      tick(0, 0, 1, 0, 2);
      tick(1, 0, 1, 0, 7);
      tick(1, 0, 1, 3, 6);
      for (int k = 0; k < 2 * NSLOT + OP_LAT; k++) begin
         tick(1, 0, 0, 0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL last_wins tick=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            bad++;
         end
      end
   endtask

   task automatic test_halt();
      for (int k = 0; k < 40 && m_last_slot != 5; k++) tick(1, 0, 0, 0, 0);
      total++;
      if (m_last_slot != 5) begin
         $display("FAIL halt_sync last=%0d exp=5", m_last_slot);
         bad++;
      end
      for (int k = 0; k < NSLOT; k++) begin
         tick(1, 1, 0, 0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL halt tick=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            bad++;
         end
      end
      total++;
      if (bus.slot_vld !== 1'b0) begin
         $display("FAIL halt_parked slot_vld=%b exp=0", bus.slot_vld);
         bad++;
      end
      for (int k = 0; k < 2 * NSLOT + OP_LAT + 2; k++) begin
         tick(1, 0, (k == 0), 2, 3);
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL halt_release tick=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            bad++;
         end
      end
   endtask

   task automatic test_sparse_en();
      for (int k = 0; k < 360; k++) begin
         tick((k % 6) == 5, ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL sparse_en cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            bad++;
         end
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 60 && m_last_slot != 7; k++) tick(1, 0, ($urandom_range(0, 3) == 0), 1, 4);
      total++;
      if (m_last_slot != 7) begin
         $display("FAIL async_sync last=%0d exp=7", m_last_slot);
         bad++;
      end
      #2;
      rst_n = 0;
      #1;
      total++;
      if (obs_vec() !== 15'h0) begin
         $display("FAIL async_reset_outputs got=%h exp=%h", obs_vec(), 15'h0);
         bad++;
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      for (int k = 0; k < 2 * NSLOT + OP_LAT + 2; k++) begin
         tick(1, 0, 0, 0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL async_reset_after tick=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            bad++;
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         tick($urandom_range(0, 3) != 0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL random cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_alg_write();
      test_last_wins();
      test_halt();
      test_sparse_en();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
